input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Parametrised multi-channel input front end for the traffic light controller.
- Per channel: multi-stage synchroniser, counter-based debounce filter, single-cycle rising/falling edge pulses.
- Replaces the fixed 4-signal synchroniser. Sits between the raw pins (Sensor, Walk_Request, Reprogram, external reset request) and the FSM/divider logic.
- Top-level channel map: bit0 Sensor, bit1 Walk_Request, bit2 Reprogram, bit3 external reset request.

Parameters:
- N_CH, 4, number of independent input channels (1..32).
- SYNC_STAGES, 2, flip-flops in each synchroniser chain (2..4).
- DEBOUNCE_CYCLES, 4, consecutive stable cycles needed to change the filtered level (1..65535).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, do not override.

Ports:
- clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- async_in  in  N_CH  raw asynchronous inputs.
- sync_out  out  N_CH  synchronised, unfiltered levels (last synchroniser stage).
- level_out  out  N_CH  debounced levels.
- rise_pulse  out  N_CH  one-cycle pulse when level_out goes 0->1.
- fall_pulse  out  N_CH  one-cycle pulse when level_out goes 1->0.
- clear_req  in  N_CH  sticky-flag clear; present only with STICKY_REQ_EN.
- req_flag  out  N_CH  sticky request flags; present only with STICKY_REQ_EN.

Behaviour:
- Reset is asynchronous, active-high; all flops clear immediately when Reset=1.
- Reset values: sync chain 0, counters 0, level_out 0, rise_pulse 0, fall_pulse 0, req_flag 0.
- Synchroniser:
  - Per channel, shift register of SYNC_STAGES flops; sync_out = last stage.
  - Input stable before edge 0 appears on sync_out after edge SYNC_STAGES-1.
- Debounce, per channel, counter cnt:
  - sync_out == level_out: cnt <= 0.
  - sync_out != level_out and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync_out != level_out and cnt == DEBOUNCE_CYCLES-1: level_out <= sync_out, cnt <= 0.
  - level_out changes after exactly DEBOUNCE_CYCLES consecutive differing cycles. Any matching cycle restarts the count; the counter never wraps.
  - DEBOUNCE_CYCLES=1: level_out follows sync_out with one cycle delay.
- End-to-end latency: a clean edge appears on level_out SYNC_STAGES+DEBOUNCE_CYCLES clocks after the first capturing edge. Defaults: 6 clocks.
- Edge pulses:
  - Registered; asserted for exactly one cycle, in the same cycle level_out takes its new value.
  - rise_pulse and fall_pulse are mutually exclusive per channel.
- Channels are fully independent; simultaneous transitions on multiple channels give simultaneous pulses.
- Reset mid-debounce: the count is discarded; the channel restarts from level 0 after Reset is released.
- A held-high input at reset release yields rise_pulse after SYNC_STAGES+DEBOUNCE_CYCLES clocks.
- No other state machine; per-channel state is implied by (level_out, cnt).

Optional Feature:
- Macro: INPUT_COND_STICKY_REQ_EN.
- Defined:
  - Adds clear_req and req_flag.
  - req_flag[i] is set on rise_pulse[i] and held until clear_req[i]=1.
  - Set takes priority when rise_pulse[i] and clear_req[i] occur in the same cycle.
  - Used by the FSM to latch walk requests during green.
- Undefined: ports and flag logic absent; all other behaviour identical.

Decomposition:
- Shared package input_cond_pkg: channel index constants (CH_SENSOR=0, CH_WALK=1, CH_PROG=2, CH_RST=3), default parameter values, and a CNT_W helper function.
- One natural sub-module, ic_channel: single-channel sync chain, debounce, and edge detect.
- The top instantiates ic_channel N_CH times in a generate loop; the sticky flag lives in ic_channel under the macro.

Test Plan:
- Reset held 3 cycles, all inputs 0 -> every output 0. Assert Reset asynchronously mid-cycle with level_out=4'b1111 -> all outputs 0 before the next edge.
- async_in[1] 0->1 and held (defaults) -> sync_out[1]=1 after 2 edges, level_out[1]=1 and rise_pulse[1]=1 after edge 6, rise_pulse[1]=0 at edge 7.
- async_in[0] glitch high for 3 cycles then low -> level_out[0] stays 0, no pulses. Glitch of 4 cycles -> level_out[0]=1 for ≥1 cycle with rise_pulse, then fall_pulse 4 cycles after return.
- async_in=4'b1010 then 4'b0101 after level settles -> fall_pulse=4'b1010 and rise_pulse=4'b0101 in the same cycle.
- DEBOUNCE_CYCLES=1, SYNC_STAGES=3 -> level_out follows input 4 clocks after capture.
- With INPUT_COND_STICKY_REQ_EN: walk rise sets req_flag[1]. clear_req[1] 2 cycles later -> req_flag[1]=0 next cycle. Coincident rise and clear -> req_flag[1] stays 1.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner: channel map, default sizing
// and the debounce counter width helper.
package input_cond_pkg;

    localparam int CH_SENSOR = 0;
    localparam int CH_WALK   = 1;
    localparam int CH_PROG   = 2;
    localparam int CH_RST    = 3;

    localparam int DEF_N_CH            = 4;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

    // Wide enough to hold DEBOUNCE_CYCLES itself, so DEBOUNCE_CYCLES=1 still gets one bit.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Bundle of raw inputs and conditioned outputs between the pins and the controller.
// The sticky request pair exists only when INPUT_COND_STICKY_REQ_EN is defined.
interface input_conditioner_if
    import input_cond_pkg::*;
#(
    parameter int N_CH = DEF_N_CH
);

    logic [N_CH-1:0] async_in;
    logic [N_CH-1:0] sync_out;
    logic [N_CH-1:0] level_out;
    logic [N_CH-1:0] rise_pulse;
    logic [N_CH-1:0] fall_pulse;

`ifdef INPUT_COND_STICKY_REQ_EN
    logic [N_CH-1:0] clear_req;
    logic [N_CH-1:0] req_flag;

    modport master (
        output async_in,
        output clear_req,
        input  sync_out,
        input  level_out,
        input  rise_pulse,
        input  fall_pulse,
        input  req_flag
    );

    modport slave (
        input  async_in,
        input  clear_req,
        output sync_out,
        output level_out,
        output rise_pulse,
        output fall_pulse,
        output req_flag
    );
`else
    modport master (
        output async_in,
        input  sync_out,
        input  level_out,
        input  rise_pulse,
        input  fall_pulse
    );

    modport slave (
        input  async_in,
        output sync_out,
        output level_out,
        output rise_pulse,
        output fall_pulse
    );
`endif

endinterface

// File: rtl/input_conditioner_ic_channel.sv
// One input channel: synchroniser chain, counter debounce and registered edge pulses.
// With INPUT_COND_STICKY_REQ_EN the channel also keeps a sticky request flag.
module ic_channel
    import input_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic Reset,
    input  logic async_in,
`ifdef INPUT_COND_STICKY_REQ_EN
    input  logic clear_req,
    output logic req_flag,
`endif
    output logic sync_out,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   differ;
    logic                   commit;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign differ   = (sync_out != level_out);
    assign commit   = differ && (cnt == CNT_LAST);

    // The count only advances while the synchronised level disagrees; it is
    // cleared on agreement or on commit, so it can never wrap.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cnt        <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= commit && sync_out;
            fall_pulse <= commit && !sync_out;
            if (commit) begin
                level_out <= sync_out;
                cnt       <= '0;
            end else if (differ) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

`ifdef INPUT_COND_STICKY_REQ_EN
    // A new rising edge wins over a clear arriving in the same cycle.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            req_flag <= 1'b0;
        end else if (rise_pulse) begin
            req_flag <= 1'b1;
        end else if (clear_req) begin
            req_flag <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input front end: N_CH independent ic_channel instances.
// Define INPUT_COND_STICKY_REQ_EN to add the clear_req/req_flag sticky requests.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int N_CH            = DEF_N_CH,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input logic                clk,
    input logic                Reset,
    input_conditioner_if.slave bus
);

    logic [N_CH-1:0] sync_vec;
    logic [N_CH-1:0] level_vec;
    logic [N_CH-1:0] rise_vec;
    logic [N_CH-1:0] fall_vec;
`ifdef INPUT_COND_STICKY_REQ_EN
    logic [N_CH-1:0] flag_vec;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ic_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk        (clk),
            .Reset      (Reset),
            .async_in   (bus.async_in[i]),
`ifdef INPUT_COND_STICKY_REQ_EN
            .clear_req  (bus.clear_req[i]),
            .req_flag   (flag_vec[i]),
`endif
            .sync_out   (sync_vec[i]),
            .level_out  (level_vec[i]),
            .rise_pulse (rise_vec[i]),
            .fall_pulse (fall_vec[i])
        );
    end

    assign bus.sync_out   = sync_vec;
    assign bus.level_out  = level_vec;
    assign bus.rise_pulse = rise_vec;
    assign bus.fall_pulse = fall_vec;
`ifdef INPUT_COND_STICKY_REQ_EN
    assign bus.req_flag   = flag_vec;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: default build (S=2,D=4) plus a fast
// S=3,D=1 instance; sticky-flag scenarios run when INPUT_COND_STICKY_REQ_EN is defined.
module tb_input_conditioner;
    import input_cond_pkg::*;

    localparam int NC = DEF_N_CH;
    localparam int SA = 2;
    localparam int DA = 4;
    localparam int SB = 3;
    localparam int DB = 1;

    logic          clk = 1'b0;
    logic          Reset;
    logic [NC-1:0] a_drv;
    logic [NC-1:0] clr_drv;
    int            tests_run = 0;
    int            tests_failed = 0;

    always #5 clk = ~clk;

    input_conditioner_if #(.N_CH(NC)) bus_a ();
    input_conditioner_if #(.N_CH(NC)) bus_b ();

    assign bus_a.async_in = a_drv;
    assign bus_b.async_in = a_drv;
`ifdef INPUT_COND_STICKY_REQ_EN
    assign bus_a.clear_req = clr_drv;
    assign bus_b.clear_req = '0;
`endif

    input_conditioner #(.N_CH(NC), .SYNC_STAGES(SA), .DEBOUNCE_CYCLES(DA)) dut_a (
        .clk(clk), .Reset(Reset), .bus(bus_a.slave));
    input_conditioner #(.N_CH(NC), .SYNC_STAGES(SB), .DEBOUNCE_CYCLES(DB)) dut_b (
        .clk(clk), .Reset(Reset), .bus(bus_b.slave));

    // Reference model: delay lines of samples and a window of the last DA
    // synchronised values; a level flips when the whole window disagrees with it.
    logic [NC-1:0] pipe_q[$];
    logic [NC-1:0] win_q[$];
    logic [NC-1:0] b_hist[$];
    logic [NC-1:0] m_sync, m_level, m_rise, m_fall, m_flag;
    logic [NC-1:0] mb_level, mb_rise, mb_fall;

    function automatic void model_reset();
        pipe_q.delete();
        for (int k = 0; k < SA; k++) pipe_q.push_back('0);
        win_q.delete();
        b_hist.delete();
        m_sync = '0; m_level = '0; m_rise = '0; m_fall = '0; m_flag = '0;
        mb_level = '0; mb_rise = '0; mb_fall = '0;
    endfunction

    function automatic void model_step();
        logic [NC-1:0] deb_in, prev_rise, b_new;
        bit all_diff;
        if (Reset) begin
            model_reset();
            return;
        end
        prev_rise = m_rise;
        deb_in = pipe_q[0];
        pipe_q.push_back(a_drv);
        void'(pipe_q.pop_front());
        m_sync = pipe_q[0];
        win_q.push_back(deb_in);
        if (win_q.size() > DA) void'(win_q.pop_front());
        m_rise = '0;
        m_fall = '0;
        for (int ch = 0; ch < NC; ch++) begin
            if (win_q.size() == DA) begin
                all_diff = 1'b1;
                foreach (win_q[k]) if (win_q[k][ch] == m_level[ch]) all_diff = 1'b0;
                if (all_diff) begin
                    m_level[ch] = ~m_level[ch];
                    if (m_level[ch]) m_rise[ch] = 1'b1;
                    else             m_fall[ch] = 1'b1;
                end
            end
        end
        m_flag = (m_flag & ~clr_drv) | prev_rise;
        // Fast instance: level equals the input captured SB+DB-1 edges earlier.
        b_hist.push_back(a_drv);
        if (b_hist.size() > SB + DB) void'(b_hist.pop_front());
        b_new = (b_hist.size() == SB + DB) ? b_hist[0] : '0;
        mb_rise = b_new & ~mb_level;
        mb_fall = ~b_new & mb_level;
        mb_level = b_new;
    endfunction

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; a_drv = '0; clr_drv = '0;
        model_reset();
        cycle(3);
        tests_run++;
        if ({bus_a.sync_out, bus_a.level_out, bus_a.rise_pulse, bus_a.fall_pulse} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs_a: got %h, expected 0",
                     {bus_a.sync_out, bus_a.level_out, bus_a.rise_pulse, bus_a.fall_pulse});
        end
        tests_run++;
        if ({bus_b.sync_out, bus_b.level_out, bus_b.rise_pulse, bus_b.fall_pulse} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs_b: got %h, expected 0",
                     {bus_b.sync_out, bus_b.level_out, bus_b.rise_pulse, bus_b.fall_pulse});
        end
        Reset = 1'b0; a_drv = '1;
        cycle(8);
        tests_run++;
        if (bus_a.level_out !== 4'b1111) begin
            tests_failed++;
            $display("[TB] FAIL pre_async_reset_level: got %b, expected 1111", bus_a.level_out);
        end
        #2 Reset = 1'b1;
        #1;
        model_reset();
        tests_run++;
        if ({bus_a.sync_out, bus_a.level_out, bus_a.rise_pulse, bus_a.fall_pulse} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_midcycle: got %h, expected 0",
                     {bus_a.sync_out, bus_a.level_out, bus_a.rise_pulse, bus_a.fall_pulse});
        end
        cycle(2);
    endtask

    // Input held high while reset releases: rise appears SA+DA clocks later.
    task automatic test_reset_release();
        logic [NC-1:0] exp;
        Reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            cycle(1);
            exp = (e == SA + DA) ? 4'b1111 : 4'b0000;
            tests_run++;
            if (bus_a.rise_pulse !== exp) begin
                tests_failed++;
                $display("[TB] FAIL release_rise_e%0d: got %b, expected %b", e, bus_a.rise_pulse, exp);
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        logic [NC-1:0] exp;
        a_drv = '0;
        cycle(10);
        a_drv = 4'b0100;
        cycle(4);
        tests_run++;
        if (bus_a.level_out !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL mid_debounce_level: got %b, expected 0000", bus_a.level_out);
        end
        Reset = 1'b1;
        cycle(2);
        Reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            cycle(1);
            exp = (e == SA + DA) ? 4'b0100 : 4'b0000;
            tests_run++;
            if (bus_a.rise_pulse !== exp) begin
                tests_failed++;
                $display("[TB] FAIL mid_debounce_rise_e%0d: got %b, expected %b", e, bus_a.rise_pulse, exp);
            end
        end
    endtask

    task automatic test_walk_edge();
        a_drv = '0;
        cycle(10);
        a_drv[CH_WALK] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            cycle(1);
            tests_run++;
            if (bus_a.sync_out[CH_WALK] !== (e >= SA)) begin
                tests_failed++;
                $display("[TB] FAIL walk_sync_e%0d: got %b, expected %b", e, bus_a.sync_out[CH_WALK], e >= SA);
            end
            tests_run++;
            if (bus_a.level_out[CH_WALK] !== (e >= SA + DA)) begin
                tests_failed++;
                $display("[TB] FAIL walk_level_e%0d: got %b, expected %b", e, bus_a.level_out[CH_WALK], e >= SA + DA);
            end
            tests_run++;
            if (bus_a.rise_pulse !== ((e == SA + DA) ? 4'b0010 : 4'b0000)) begin
                tests_failed++;
                $display("[TB] FAIL walk_rise_e%0d: got %b, expected %b", e, bus_a.rise_pulse,
                         (e == SA + DA) ? 4'b0010 : 4'b0000);
            end
        end
    endtask

    task automatic test_glitch();
        int bad, rise_e, fall_e;
        a_drv = '0;
        cycle(10);
        bad = 0;
        a_drv[CH_SENSOR] = 1'b1;
        cycle(3);
        a_drv[CH_SENSOR] = 1'b0;
        for (int e = 0; e < 10; e++) begin
            cycle(1);
            if (bus_a.level_out[0] || bus_a.rise_pulse[0] || bus_a.fall_pulse[0]) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL glitch3_filtered: got %0d active cycles, expected 0", bad);
        end
        rise_e = -1; fall_e = -1;
        a_drv[CH_SENSOR] = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            cycle(1);
            if (e == 4) a_drv[CH_SENSOR] = 1'b0;
            if (bus_a.rise_pulse[0]) rise_e = e;
            if (bus_a.fall_pulse[0]) fall_e = e;
            tests_run++;
            if (bus_a.level_out !== m_level) begin
                tests_failed++;
                $display("[TB] FAIL glitch4_level_e%0d: got %b, expected %b", e, bus_a.level_out, m_level);
            end
        end
        tests_run++;
        if (rise_e != 6 || fall_e != 10) begin
            tests_failed++;
            $display("[TB] FAIL glitch4_edges: got rise@%0d fall@%0d, expected rise@6 fall@10", rise_e, fall_e);
        end
    endtask

    task automatic test_simultaneous();
        bit found;
        a_drv = 4'b1010;
        cycle(10);
        tests_run++;
        if (bus_a.level_out !== 4'b1010) begin
            tests_failed++;
            $display("[TB] FAIL simul_settle: got %b, expected 1010", bus_a.level_out);
        end
        a_drv = 4'b0101;
        found = 1'b0;
        for (int e = 1; e <= 10 && !found; e++) begin
            cycle(1);
            if ((bus_a.rise_pulse | bus_a.fall_pulse) != '0) begin
                found = 1'b1;
                tests_run++;
                if (bus_a.fall_pulse !== 4'b1010 || bus_a.rise_pulse !== 4'b0101 || e != SA + DA) begin
                    tests_failed++;
                    $display("[TB] FAIL simul_pulses: got fall=%b rise=%b @%0d, expected 1010/0101 @%0d",
                             bus_a.fall_pulse, bus_a.rise_pulse, e, SA + DA);
                end
            end
        end
        if (!found) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL simul_timeout: got no pulse in 10 cycles, expected one");
        end
    endtask

    task automatic test_fast_config();
        a_drv = '0;
        cycle(8);
        a_drv = 4'b0001;
        for (int e = 1; e <= 5; e++) begin
            cycle(1);
            tests_run++;
            if (bus_b.level_out[0] !== (e >= SB + DB)) begin
                tests_failed++;
                $display("[TB] FAIL fast_level_e%0d: got %b, expected %b", e, bus_b.level_out[0], e >= SB + DB);
            end
            tests_run++;
            if (bus_b.rise_pulse[0] !== (e == SB + DB)) begin
                tests_failed++;
                $display("[TB] FAIL fast_rise_e%0d: got %b, expected %b", e, bus_b.rise_pulse[0], e == SB + DB);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            for (int ch = 0; ch < NC; ch++)
                if ($urandom_range(3) == 0) a_drv[ch] = ~a_drv[ch];
`ifdef INPUT_COND_STICKY_REQ_EN
            clr_drv = NC'($urandom) & NC'($urandom) & NC'($urandom);
`endif
            cycle(1);
            tests_run++;
            if (bus_a.sync_out !== m_sync || bus_a.level_out !== m_level) begin
                tests_failed++;
                $display("[TB] FAIL rand_a_levels c%0d: got sync=%b level=%b, expected %b/%b",
                         c, bus_a.sync_out, bus_a.level_out, m_sync, m_level);
            end
            tests_run++;
            if (bus_a.rise_pulse !== m_rise || bus_a.fall_pulse !== m_fall) begin
                tests_failed++;
                $display("[TB] FAIL rand_a_pulses c%0d: got rise=%b fall=%b, expected %b/%b",
                         c, bus_a.rise_pulse, bus_a.fall_pulse, m_rise, m_fall);
            end
            tests_run++;
            if (bus_b.level_out !== mb_level || bus_b.rise_pulse !== mb_rise || bus_b.fall_pulse !== mb_fall) begin
                tests_failed++;
                $display("[TB] FAIL rand_b c%0d: got l=%b r=%b f=%b, expected %b/%b/%b", c,
                         bus_b.level_out, bus_b.rise_pulse, bus_b.fall_pulse, mb_level, mb_rise, mb_fall);
            end
            tests_run++;
            if ((bus_a.rise_pulse & bus_a.fall_pulse) !== '0) begin
                tests_failed++;
                $display("[TB] FAIL rand_exclusive c%0d: got overlap %b, expected 0000",
                         c, bus_a.rise_pulse & bus_a.fall_pulse);
            end
`ifdef INPUT_COND_STICKY_REQ_EN
            tests_run++;
            if (bus_a.req_flag !== m_flag) begin
                tests_failed++;
                $display("[TB] FAIL rand_flag c%0d: got %b, expected %b", c, bus_a.req_flag, m_flag);
            end
`endif
        end
        clr_drv = '0;
    endtask

`ifdef INPUT_COND_STICKY_REQ_EN
    task automatic wait_walk_rise(input string name);
        bit seen;
        seen = 1'b0;
        for (int e = 0; e < 10 && !seen; e++) begin
            cycle(1);
            if (bus_a.rise_pulse[CH_WALK]) seen = 1'b1;
        end
        if (!seen) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s_timeout: got no walk rise, expected one within 10 cycles", name);
        end
    endtask

    task automatic test_sticky();
        a_drv = '0; clr_drv = '1;
        cycle(10);
        clr_drv = '0;
        a_drv[CH_WALK] = 1'b1;
        wait_walk_rise("sticky_set");
        cycle(1);
        tests_run++;
        if (bus_a.req_flag[CH_WALK] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL sticky_set: got %b, expected 1", bus_a.req_flag[CH_WALK]);
        end
        cycle(1);
        clr_drv[CH_WALK] = 1'b1;
        cycle(1);
        clr_drv = '0;
        tests_run++;
        if (bus_a.req_flag[CH_WALK] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL sticky_clear: got %b, expected 0", bus_a.req_flag[CH_WALK]);
        end
        a_drv[CH_WALK] = 1'b0;
        cycle(10);
        a_drv[CH_WALK] = 1'b1;
        wait_walk_rise("sticky_coinc");
        clr_drv[CH_WALK] = 1'b1;
        cycle(1);
        clr_drv = '0;
        tests_run++;
        if (bus_a.req_flag[CH_WALK] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL sticky_set_priority: got %b, expected 1", bus_a.req_flag[CH_WALK]);
        end
        cycle(1);
        tests_run++;
        if (bus_a.req_flag[CH_WALK] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL sticky_hold: got %b, expected 1", bus_a.req_flag[CH_WALK]);
        end
    endtask
`endif

    initial begin
        Reset = 1'b1;
        a_drv = '0;
        clr_drv = '0;
        test_reset();
        test_reset_release();
        test_reset_mid_debounce();
        test_walk_edge();
        test_glitch();
        test_simultaneous();
        test_fast_config();
        test_random();
`ifdef INPUT_COND_STICKY_REQ_EN
        test_sticky();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
